// File: rtl/icepic_sys_ctrl.sv
// icepic_12 system controller: reset stretch, watchdog,
// SLEEP/wake sequencing and TO/PD status bits.
module icepic_sys_ctrl #(
  parameter int POR_CYCLES    = 16,
  parameter int WDT_BASE_BITS = 11,
  parameter int WAKE_PINS     = 4
) (
  input  logic                 clk_in,
  input  logic                 reset_n_in,
  input  logic                 clrwdt_in,
  input  logic                 sleep_in,
  input  logic                 wdt_en_in,
  input  logic                 psa_in,
  input  logic [2:0]           ps_in,
  input  logic [WAKE_PINS-1:0] wake_pins_in,
  output logic                 core_reset_out,
  output logic                 core_en_out,
  output logic                 to_n_out,
  output logic                 pd_n_out,
  output logic                 wdt_timeout_out
);

  localparam int CW =
    (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_POR,
    ST_RUN,
    ST_SLEEP,
    ST_WAKE_RST
  } state_t;

  state_t                 state;
  logic [CW-1:0]          rst_cnt;
  logic [WDT_BASE_BITS-1:0] base_cnt;
  logic [6:0]             pre_cnt;
  logic [6:0]             ps_mask;
  logic [WAKE_PINS-1:0]   pin_s1;
  logic [WAKE_PINS-1:0]   pin_s2;
  logic [WAKE_PINS-1:0]   pin_snap;
  logic                   pin_diff;

  logic in_run;
  logic in_sleep;
  logic wdt_live;
  logic wdt_ovf;
  logic wdt_hit;
  logic run_clr;
  logic wdt_tmo;
  logic pin_wake;
  logic wdt_clr;
  logic rst_done;

  assign in_run   = (state == ST_RUN);
  assign in_sleep = (state == ST_SLEEP);
  assign wdt_live = (in_run || in_sleep) && wdt_en_in;

  // ratio 2^ps: last prescaler value before timeout
  assign ps_mask  = 7'h7f >> (3'd7 - ps_in);

  assign wdt_ovf  = wdt_live && (&base_cnt);
  assign wdt_hit  = wdt_ovf &&
                    (!psa_in || (pre_cnt == ps_mask));
  assign run_clr  = in_run && clrwdt_in;
  assign wdt_tmo  = wdt_hit && !run_clr;
  assign pin_wake = in_sleep && pin_diff;

  assign wdt_clr  = !(in_run || in_sleep) ||
                    wdt_tmo || pin_wake ||
                    (in_run && (sleep_in || clrwdt_in));

  assign rst_done = (rst_cnt == CW'(POR_CYCLES - 1));

  // wake pin synchronizer and registered change detect
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      pin_s1   <= '0;
      pin_s2   <= '0;
      pin_diff <= 1'b0;
    end else begin
      pin_s1   <= wake_pins_in;
      pin_s2   <= pin_s1;
      pin_diff <= in_sleep && (pin_s2 != pin_snap);
    end
  end

  // watchdog base counter and overflow prescaler
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      base_cnt <= '0;
      pre_cnt  <= '0;
    end else if (wdt_clr) begin
      base_cnt <= '0;
      pre_cnt  <= '0;
    end else if (!wdt_en_in) begin
      base_cnt <= '0;
    end else begin
      base_cnt <= base_cnt + WDT_BASE_BITS'(1);
      if (wdt_ovf && psa_in) begin
        pre_cnt <= wdt_hit ? 7'd0 : pre_cnt + 7'd1;
      end
    end
  end

  // sequencer state, status bits and core controls
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state           <= ST_POR;
      rst_cnt         <= '0;
      pin_snap        <= '0;
      core_reset_out  <= 1'b1;
      core_en_out     <= 1'b0;
      to_n_out        <= 1'b1;
      pd_n_out        <= 1'b1;
      wdt_timeout_out <= 1'b0;
    end else begin
      wdt_timeout_out <= wdt_tmo;
      unique case (state)
        ST_POR, ST_WAKE_RST: begin
          if (rst_done) begin
            state          <= ST_RUN;
            rst_cnt        <= '0;
            core_reset_out <= 1'b0;
            core_en_out    <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + CW'(1);
          end
        end
        ST_RUN: begin
          if (wdt_tmo) begin
            state          <= ST_WAKE_RST;
            to_n_out       <= 1'b0;
            pd_n_out       <= 1'b1;
            core_reset_out <= 1'b1;
            core_en_out    <= 1'b0;
          end else if (sleep_in) begin
            state       <= ST_SLEEP;
            to_n_out    <= 1'b1;
            pd_n_out    <= 1'b0;
            core_en_out <= 1'b0;
            pin_snap    <= pin_s2;
          end else if (clrwdt_in) begin
            to_n_out <= 1'b1;
            pd_n_out <= 1'b1;
          end
        end
        ST_SLEEP: begin
          if (wdt_tmo) begin
            state          <= ST_WAKE_RST;
            to_n_out       <= 1'b0;
            core_reset_out <= 1'b1;
          end else if (pin_diff) begin
            state          <= ST_WAKE_RST;
            to_n_out       <= 1'b1;
            core_reset_out <= 1'b1;
          end
        end
        default: begin
          state          <= ST_POR;
          rst_cnt        <= '0;
          core_reset_out <= 1'b1;
          core_en_out    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icepic_sys_ctrl.sv
// Bench for icepic_sys_ctrl: directed plan plus random
// stimulus against a cycle-level behavioural model.
module tb_icepic_sys_ctrl;

  localparam int PC = 16;
  localparam int BB = 4;
  localparam int WP = 4;

  localparam int M_POR = 0;
  localparam int M_RUN = 1;
  localparam int M_SLP = 2;
  localparam int M_WR  = 3;

  logic          clk_in = 1'b0;
  logic          reset_n_in = 1'b0;
  logic          clrwdt_in = 1'b0;
  logic          sleep_in = 1'b0;
  logic          wdt_en_in = 1'b1;
  logic          psa_in = 1'b0;
  logic [2:0]    ps_in = 3'd0;
  logic [WP-1:0] wake_pins_in = '0;
  logic          core_reset_out;
  logic          core_en_out;
  logic          to_n_out;
  logic          pd_n_out;
  logic          wdt_timeout_out;

  always #5 clk_in = ~clk_in;

  icepic_sys_ctrl #(
    .POR_CYCLES   (PC),
    .WDT_BASE_BITS(BB),
    .WAKE_PINS    (WP)
  ) dut (
    .clk_in         (clk_in),
    .reset_n_in     (reset_n_in),
    .clrwdt_in      (clrwdt_in),
    .sleep_in       (sleep_in),
    .wdt_en_in      (wdt_en_in),
    .psa_in         (psa_in),
    .ps_in          (ps_in),
    .wake_pins_in   (wake_pins_in),
    .core_reset_out (core_reset_out),
    .core_en_out    (core_en_out),
    .to_n_out       (to_n_out),
    .pd_n_out       (pd_n_out),
    .wdt_timeout_out(wdt_timeout_out)
  );

  int n_tot = 0;
  int n_pass = 0;

  int m_mode, m_cnt, m_base, m_pre, m_prev;
  bit m_to, m_pd, m_tmo;
  logic [WP-1:0] m_snap, q0, q1, q2;

  task automatic chk(input string nm,
                     input int act, input int want);
    n_tot++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d @%0t",
                  nm, act, want, $time);
  endtask

  function automatic void m_reset();
    m_mode = M_POR; m_cnt = 0;
    m_base = 0; m_pre = 0; m_prev = M_POR;
    m_to = 1; m_pd = 1; m_tmo = 0;
    m_snap = '0; q0 = '0; q1 = '0; q2 = '0;
  endfunction

  function automatic void m_wclr();
    m_base = 0; m_pre = 0;
  endfunction

  // one clock of the model, using inputs seen at that edge
  function automatic void m_step();
    int old, mask;
    bit ovf, raw, tmo, pwake;
    old   = m_mode;
    mask  = (1 << ps_in) - 1;
    ovf   = (m_mode == M_RUN || m_mode == M_SLP) &&
            wdt_en_in && (m_base == (1 << BB) - 1);
    raw   = ovf && (!psa_in || m_pre == mask);
    tmo   = raw && !(m_mode == M_RUN && clrwdt_in);
    // pin captured three edges ago vs sleep snapshot
    pwake = m_mode == M_SLP && m_prev == M_SLP &&
            q2 != m_snap;
    m_tmo = tmo;
    case (m_mode)
      M_POR, M_WR: begin
        m_wclr();
        m_cnt++;
        if (m_cnt == PC) begin
          m_mode = M_RUN; m_cnt = 0;
        end
      end
      M_RUN: begin
        if (tmo) begin
          m_mode = M_WR; m_to = 0; m_pd = 1; m_wclr();
        end else if (sleep_in) begin
          m_mode = M_SLP; m_to = 1; m_pd = 0;
          m_snap = q1; m_wclr();
        end else if (clrwdt_in) begin
          m_to = 1; m_pd = 1; m_wclr();
        end else m_wadv(ovf, raw);
      end
      default: begin
        if (tmo) begin
          m_mode = M_WR; m_to = 0; m_wclr();
        end else if (pwake) begin
          m_mode = M_WR; m_to = 1; m_wclr();
        end else m_wadv(ovf, raw);
      end
    endcase
    q2 = q1; q1 = q0; q0 = wake_pins_in;
    m_prev = old;
  endfunction

  function automatic void m_wadv(bit ovf, bit raw);
    if (!wdt_en_in) m_base = 0;
    else if (ovf) begin
      m_base = 0;
      if (psa_in) m_pre = raw ? 0 : (m_pre + 1) % 128;
    end else m_base++;
  endfunction

  // advance model one clock and compare every output
  task automatic cyc();
    @(negedge clk_in);
    if (!reset_n_in) m_reset();
    else m_step();
    chk("core_reset", core_reset_out,
        int'(m_mode == M_POR || m_mode == M_WR));
    chk("core_en", core_en_out, int'(m_mode == M_RUN));
    chk("to_n", to_n_out, int'(m_to));
    chk("pd_n", pd_n_out, int'(m_pd));
    chk("wdt_timeout", wdt_timeout_out, int'(m_tmo));
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  int seen;
  int idx;

  initial begin
    m_reset();
    run(3);
    chk("rst_core_reset", core_reset_out, 1);
    chk("rst_core_en", core_en_out, 0);
    chk("rst_to_n", to_n_out, 1);
    chk("rst_pd_n", pd_n_out, 1);
    chk("rst_tmo", wdt_timeout_out, 0);
    #1 reset_n_in = 1'b1;
    chk("por_c0", core_reset_out, 1);
    for (int c = 1; c <= 16; c++) begin
      cyc();
      chk("por_hold", core_reset_out, int'(c < 16));
      chk("por_en", core_en_out, int'(c >= 16));
    end

    // plain WDT timeout, ratio 1
    run(15);
    chk("wdt1_pre", wdt_timeout_out, 0);
    run(1);
    chk("wdt1_pulse", wdt_timeout_out, 1);
    chk("wdt1_to", to_n_out, 0);
    chk("wdt1_pd", pd_n_out, 1);
    chk("wdt1_rst", core_reset_out, 1);
    run(15);
    chk("wr_hold", core_reset_out, 1);
    run(1);
    chk("wr_done", core_reset_out, 0);
    chk("wr_en", core_en_out, 1);
    chk("wr_to_kept", to_n_out, 0);

    // prescaler 1:8 -> 128 cycles
    psa_in = 1'b1; ps_in = 3'd3;
    run(127);
    chk("ps8_pre", wdt_timeout_out, 0);
    run(1);
    chk("ps8_pulse", wdt_timeout_out, 1);
    run(16);
    clrwdt_in = 1'b1; cyc(); clrwdt_in = 1'b0;
    chk("clr_to", to_n_out, 1);
    seen = 0;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 99; k++) begin
        cyc();
        if (wdt_timeout_out) seen++;
      end
      clrwdt_in = 1'b1; cyc(); clrwdt_in = 1'b0;
    end
    chk("clr100_none", seen, 0);
    chk("clr100_to", to_n_out, 1);

    // sleep, WDT off, pin wake
    psa_in = 1'b0; wdt_en_in = 1'b0;
    sleep_in = 1'b1; cyc(); sleep_in = 1'b0;
    chk("slp_en", core_en_out, 0);
    chk("slp_pd", pd_n_out, 0);
    chk("slp_to", to_n_out, 1);
    run(50);
    chk("slp_stay", core_reset_out, 0);
    wake_pins_in[2] = 1'b1;
    run(3);
    chk("pin_lat_early", core_reset_out, 0);
    run(1);
    chk("pin_wake", core_reset_out, 1);
    chk("pin_to", to_n_out, 1);
    chk("pin_pd", pd_n_out, 0);
    run(16);
    chk("pin_run", core_en_out, 1);

    // sleep, WDT wake
    wdt_en_in = 1'b1;
    sleep_in = 1'b1; cyc(); sleep_in = 1'b0;
    run(15);
    chk("swdt_pre", core_reset_out, 0);
    run(1);
    chk("swdt_rst", core_reset_out, 1);
    chk("swdt_to", to_n_out, 0);
    chk("swdt_pd", pd_n_out, 0);
    chk("swdt_pulse", wdt_timeout_out, 1);
    run(16);

    // clrwdt on the timeout cycle, then reset in WAKE_RST
    run(15);
    clrwdt_in = 1'b1; cyc(); clrwdt_in = 1'b0;
    chk("race_nopulse", wdt_timeout_out, 0);
    chk("race_run", core_reset_out, 0);
    chk("race_to", to_n_out, 1);
    run(15);
    chk("race_pre", wdt_timeout_out, 0);
    run(1);
    chk("race_pulse", wdt_timeout_out, 1);
    run(5);
    #2 reset_n_in = 1'b0;
    m_reset();
    #1;
    chk("async_rst", core_reset_out, 1);
    chk("async_en", core_en_out, 0);
    chk("async_to", to_n_out, 1);
    chk("async_pd", pd_n_out, 1);
    chk("async_tmo", wdt_timeout_out, 0);
    run(3);
    #1 reset_n_in = 1'b1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc();
      clrwdt_in = ($urandom % 40) == 0;
      sleep_in  = ($urandom % 80) == 0;
      if ($urandom % 200 == 0) wdt_en_in = ($urandom % 4) != 0;
      if ($urandom % 150 == 0) psa_in = $urandom % 2;
      if ($urandom % 150 == 0) ps_in = 3'($urandom % 4);
      if ($urandom % 60 == 0) begin
        idx = $urandom % WP;
        wake_pins_in[idx] = ~wake_pins_in[idx];
      end
      if ($urandom % 1500 == 0) begin
        #2 reset_n_in = 1'b0;
        m_reset();
        run(2);
        #1 reset_n_in = 1'b1;
      end
    end
    clrwdt_in = 1'b0; sleep_in = 1'b0;
    run(4);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
